// File: rtl/arkhe_braid_arbiter.sv
// rtl/arkhe_braid_arbiter.sv - N-core handover arbiter onto one braid channel
// Priority arbitration with round-robin tie-break and age promotion of starved slots.
module arkhe_braid_arbiter #(
  parameter  int N_CORES   = 4,
  parameter  int AGE_LIMIT = 64,
  parameter  int AGE_W     = 7,
  localparam int CORE_W    = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [N_CORES-1:0]    hs_strobe,
  input  logic [4*N_CORES-1:0]  hs_priority,
  input  logic [32*N_CORES-1:0] hs_phase,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CORE_W-1:0]     out_core,
  output logic [3:0]            out_priority,
  output logic [31:0]           out_phase,
  output logic                  out_promoted,
  output logic [N_CORES-1:0]    pending_mask,
  output logic [15:0]           drop_count
);

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_pri   [N_CORES];
  logic [31:0]         r_phase [N_CORES];
  logic [AGE_W-1:0]    r_age   [N_CORES];
  logic [N_CORES-1:0]  r_pend;
  logic [CORE_W-1:0]   r_rr;
  logic [CORE_W-1:0]   r_win;
  logic                r_rearm;
  logic [15:0]         r_drop;

  logic [3:0]          w_ep    [N_CORES];
  logic [N_CORES-1:0]  w_aged;
  logic [N_CORES-1:0]  w_ovw;
  logic [CORE_W:0]     w_drops;
  logic [16:0]         w_drop_sum;
  logic                w_found;
  logic [CORE_W-1:0]   w_sel;
  logic [3:0]          w_best;
  logic [CORE_W:0]     w_sum;
  logic [CORE_W-1:0]   w_idx;
  logic                w_load;
  logic                w_accept;

  assign out_valid    = (r_state == S_HOLD);
  assign out_core     = r_win;
  assign pending_mask = r_pend;
  assign drop_count   = r_drop;
  assign w_ovw        = hs_strobe & r_pend;

  always_comb begin
    w_aged  = '0;
    w_drops = '0;
    for (int i = 0; i < N_CORES; i++) begin
      w_aged[i] = (r_age[i] == AGE_W'(AGE_LIMIT));
      w_ep[i]   = w_aged[i] ? 4'hF : r_pri[i];
      w_drops   = w_drops + (CORE_W+1)'(w_ovw[i]);
    end
    w_drop_sum = {1'b0, r_drop} + 17'(w_drops);
  end

  // Scan from rr_ptr upward; strict '>' keeps the first index in scan order on ties.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_best  = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < N_CORES; k++) begin
      w_sum = {1'b0, r_rr} + (CORE_W+1)'(k);
      if (w_sum >= (CORE_W+1)'(N_CORES)) begin
        w_sum = w_sum - (CORE_W+1)'(N_CORES);
      end
      w_idx = w_sum[CORE_W-1:0];
      if (r_pend[w_idx] && (!w_found || (w_ep[w_idx] > w_best))) begin
        w_found = 1'b1;
        w_sel   = w_idx;
        w_best  = w_ep[w_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en && w_found) begin
          w_load      = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
      for (int i = 0; i < N_CORES; i++) begin
        r_pri[i]   <= '0;
        r_phase[i] <= '0;
        r_age[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_CORES; i++) begin
        if (hs_strobe[i]) begin
          r_pri[i]   <= hs_priority[4*i +: 4];
          r_phase[i] <= hs_phase[32*i +: 32];
          r_age[i]   <= '0;
        end else if (r_pend[i] && !(out_valid && (r_win == CORE_W'(i)))
                     && (r_age[i] != AGE_W'(AGE_LIMIT))) begin
          r_age[i] <= r_age[i] + 1'b1;
        end
        // A slot refilled while its previous event was held stays pending on accept.
        if (hs_strobe[i]) begin
          r_pend[i] <= 1'b1;
        end else if (w_accept && (r_win == CORE_W'(i)) && !r_rearm) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rearm <= 1'b0;
    end else if (w_load) begin
      r_rearm <= 1'b0;
    end else if (out_valid && hs_strobe[r_win]) begin
      r_rearm <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop <= '0;
    end else begin
      r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_win        <= '0;
      r_rr         <= '0;
      out_priority <= '0;
      out_phase    <= '0;
      out_promoted <= 1'b0;
    end else begin
      if (w_load) begin
        r_win        <= w_sel;
        out_priority <= r_pri[w_sel];
        out_phase    <= r_phase[w_sel];
        out_promoted <= w_aged[w_sel];
      end
      if (w_accept) begin
        r_rr <= (r_win == CORE_W'(N_CORES - 1)) ? '0 : r_win + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_arkhe_braid_arbiter.sv
// tb/tb_arkhe_braid_arbiter.sv - directed bench for arkhe_braid_arbiter
// Four cores, AGE_LIMIT=8; inputs driven and outputs sampled 1ns after each rising edge.
module tb_arkhe_braid_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [3:0]   hs_strobe;
  logic [15:0]  hs_priority;
  logic [127:0] hs_phase;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_core;
  logic [3:0]   out_priority;
  logic [31:0]  out_phase;
  logic         out_promoted;
  logic [3:0]   pending_mask;
  logic [15:0]  drop_count;

  int checks = 0;
  int errors = 0;
  int cyc;
  bit prev1;
  bit done;

  arkhe_braid_arbiter #(.N_CORES(4), .AGE_LIMIT(8), .AGE_W(7)) dut (
    .clk(clk), .rst(rst), .en(en),
    .hs_strobe(hs_strobe), .hs_priority(hs_priority), .hs_phase(hs_phase),
    .out_valid(out_valid), .out_ready(out_ready), .out_core(out_core),
    .out_priority(out_priority), .out_phase(out_phase), .out_promoted(out_promoted),
    .pending_mask(pending_mask), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hs_strobe = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic strobe1(input int c, input logic [3:0] p, input logic [31:0] ph);
    hs_strobe[c]          = 1'b1;
    hs_priority[4*c +: 4] = p;
    hs_phase[32*c +: 32]  = ph;
  endtask

  task automatic expect_grant(input string tag, input int c, input logic [3:0] p,
                              input logic [31:0] ph, input logic prom);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_core"}, 32'(out_core), 32'(c));
    check({tag, "_pri"}, 32'(out_priority), 32'(p));
    check({tag, "_phase"}, out_phase, ph);
    check({tag, "_prom"}, 32'(out_promoted), 32'(prom));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; out_ready = 1'b1;
    hs_strobe = '0; hs_priority = '0; hs_phase = '0;
    do_reset();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_core", 32'(out_core), 32'd0);
    check("rst_pri", 32'(out_priority), 32'd0);
    check("rst_phase", out_phase, 32'd0);
    check("rst_prom", 32'(out_promoted), 32'd0);
    check("rst_pend", 32'(pending_mask), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);

    // Single event: pending after capture edge, valid after the next edge.
    strobe1(2, 4'hA, 32'h0000_9E37);
    step();
    hs_strobe = '0;
    check("single_pend", 32'(pending_mask), 32'h4);
    check("single_nvalid", 32'(out_valid), 32'd0);
    step();
    expect_grant("single", 2, 4'hA, 32'h0000_9E37, 1'b0);
    step();
    check("single_acc_valid", 32'(out_valid), 32'd0);
    check("single_acc_pend", 32'(pending_mask), 32'd0);

    // Priority order 1 (F), 3 (A), 0 (1), one grant every 2 cycles.
    strobe1(0, 4'h1, 32'h100);
    strobe1(1, 4'hF, 32'h101);
    strobe1(3, 4'hA, 32'h103);
    step();
    hs_strobe = '0;
    step();
    expect_grant("pri_g1", 1, 4'hF, 32'h101, 1'b0);
    step();
    check("pri_gap", 32'(out_valid), 32'd0);
    step();
    expect_grant("pri_g2", 3, 4'hA, 32'h103, 1'b0);
    step();
    step();
    expect_grant("pri_g3", 0, 4'h1, 32'h100, 1'b0);
    step();
    check("pri_pend", 32'(pending_mask), 32'd0);

    // Round-robin among equal priorities, re-strobing each winner.
    do_reset();
    for (int i = 0; i < 4; i++) strobe1(i, 4'hF, 32'h200 + 32'(i));
    step();
    hs_strobe = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      hs_strobe = '0;
      check("rr_valid", 32'(out_valid), 32'd1);
      check("rr_core", 32'(out_core), 32'(k % 4));
      check("rr_phase", out_phase, 32'h200 + 32'(k % 4));
      step();
      strobe1(k % 4, 4'hF, 32'h200 + 32'(k % 4));
    end
    hs_strobe = '0;

    // Aging: core1 keeps winning until core0 reaches AGE_LIMIT.
    do_reset();
    strobe1(0, 4'h1, 32'h300);
    strobe1(1, 4'hA, 32'h301);
    step();
    hs_strobe = '0;
    cyc = 0; prev1 = 1'b0; done = 1'b0;
    while (!done && cyc < 20) begin
      step();
      cyc++;
      hs_strobe = '0;
      if (prev1) begin
        check("age_restrobe_pend", 32'(pending_mask[1]), 32'd1);
        prev1 = 1'b0;
      end
      if (out_valid) begin
        if (out_core == 2'd0) done = 1'b1;
        else begin
          strobe1(1, 4'hA, 32'h301);
          prev1 = 1'b1;
        end
      end
    end
    check("age_in_bound", 32'(cyc <= 10), 32'd1);
    expect_grant("age", 0, 4'h1, 32'h300, 1'b1);

    // Backpressure: two overwrites of the held slot, snapshot stays, new event follows.
    do_reset();
    out_ready = 1'b0;
    strobe1(2, 4'h5, 32'h500);
    step();
    hs_strobe = '0;
    step();
    expect_grant("bp_first", 2, 4'h5, 32'h500, 1'b0);
    for (int c = 0; c < 10; c++) begin
      if (c == 2) strobe1(2, 4'h6, 32'h600);
      if (c == 5) strobe1(2, 4'h7, 32'h700);
      step();
      hs_strobe = '0;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_phase", out_phase, 32'h500);
    end
    check("bp_drop", 32'(drop_count), 32'd2);
    out_ready = 1'b1;
    step();
    check("bp_acc_valid", 32'(out_valid), 32'd0);
    check("bp_acc_pend", 32'(pending_mask), 32'h4);
    step();
    expect_grant("bp_second", 2, 4'h7, 32'h700, 1'b0);
    step();
    check("bp_final_pend", 32'(pending_mask), 32'd0);

    // en gating, grant completion with en low, reset in HOLD.
    out_ready = 1'b0;
    en = 1'b0;
    strobe1(1, 4'h3, 32'h800);
    step();
    hs_strobe = '0;
    repeat (4) step();
    check("en_nogrant", 32'(out_valid), 32'd0);
    check("en_pend", 32'(pending_mask), 32'h2);
    en = 1'b1;
    step();
    expect_grant("en_grant", 1, 4'h3, 32'h800, 1'b0);
    en = 1'b0;
    strobe1(3, 4'h2, 32'h803);
    step();
    hs_strobe = '0;
    out_ready = 1'b1;
    step();
    check("en0_acc_valid", 32'(out_valid), 32'd0);
    step();
    step();
    check("en0_nogrant", 32'(out_valid), 32'd0);
    check("en0_pend", 32'(pending_mask), 32'h8);
    en = 1'b1;
    out_ready = 1'b0;
    step();
    expect_grant("en1_grant", 3, 4'h2, 32'h803, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rsthold_valid", 32'(out_valid), 32'd0);
    check("rsthold_pend", 32'(pending_mask), 32'd0);
    check("rsthold_drop", 32'(drop_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
